// File: rtl/series_engine.sv
// series_engine: self-sequencing power-series evaluator.
//   R = sum_k (+/-) c[k] * (x^2)^k, k = 0..TERMS-1, stopping early when a
//   term exceeds the threshold y. Owns its controller, coefficient file and
//   sticky overflow flag.
// Optional feature macro: SERIES_ALT_SIGN_EN
//   defined   -> alt_i = 1 alternates term signs +, -, +, ...
//   undefined -> alt_i is ignored and no sign state is built.
module series_engine #(
  parameter int WIDTH  = 16,
  parameter int TERMS  = 8,
  parameter int COEF_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [WIDTH-1:0]           x_i,
  input  logic [WIDTH-1:0]           y_i,
  input  logic                       alt_i,
  input  logic                       coef_we_i,
  input  logic [$clog2(TERMS)-1:0]   coef_addr_i,
  input  logic [COEF_W-1:0]          coef_data_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [WIDTH-1:0]           result_o,
  output logic [$clog2(TERMS+1)-1:0] terms_used_o,
  output logic                       stopped_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(TERMS);
  localparam int TW = $clog2(TERMS+1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SQUARE = 3'd1;
  localparam logic [2:0] S_TERM   = 3'd2;
  localparam logic [2:0] S_ACCUM  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [AW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TW-1:0]    terms_q, terms_d;
  logic             stopped_q, stopped_d;
  logic             ovf_q, ovf_d;

  logic [COEF_W-1:0] coef_q [TERMS];

`ifdef SERIES_ALT_SIGN_EN
  logic alt_q, alt_d;
  logic sign_q, sign_d;
  logic sub_now;
  assign sub_now = sign_q;
`else
  logic sub_now;
  logic unused_alt;
  assign sub_now    = 1'b0;
  assign unused_alt = alt_i;
`endif

  // Full-width products; the high halves feed the overflow flag.
  logic [2*WIDTH-1:0] sq_full, term_full, pow_full;
  assign sq_full   = (2*WIDTH)'(x_q) * (2*WIDTH)'(x_q);
  assign term_full = (2*WIDTH)'(coef_q[k_q]) * (2*WIDTH)'(p_q);
  assign pow_full  = (2*WIDTH)'(p_q) * (2*WIDTH)'(x2_q);

  // Two's-complement add/sub with signed overflow detection.
  logic [WIDTH-1:0] acc_sum;
  logic             acc_ovf;
  always_comb begin
    acc_sum = '0;
    acc_ovf = 1'b0;
    if (sub_now) begin
      acc_sum = r_q - a_q;
      acc_ovf = (r_q[WIDTH-1] != a_q[WIDTH-1]) && (acc_sum[WIDTH-1] != r_q[WIDTH-1]);
    end else begin
      acc_sum = r_q + a_q;
      acc_ovf = (r_q[WIDTH-1] == a_q[WIDTH-1]) && (acc_sum[WIDTH-1] != r_q[WIDTH-1]);
    end
  end

  // Controller and datapath next-state.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    x2_d      = x2_q;
    p_d       = p_q;
    r_d       = r_q;
    a_d       = a_q;
    k_d       = k_q;
    result_d  = result_q;
    terms_d   = terms_q;
    stopped_d = stopped_q;
    ovf_d     = ovf_q;
`ifdef SERIES_ALT_SIGN_EN
    alt_d     = alt_q;
    sign_d    = sign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = x_i;
          y_d     = y_i;
`ifdef SERIES_ALT_SIGN_EN
          alt_d   = alt_i;
`endif
          state_d = S_SQUARE;
        end
      end
      S_SQUARE: begin
        x2_d      = sq_full[WIDTH-1:0];
        p_d       = WIDTH'(1);
        r_d       = '0;
        k_d       = '0;
        terms_d   = '0;
        stopped_d = 1'b0;
        ovf_d     = |sq_full[2*WIDTH-1:WIDTH];
`ifdef SERIES_ALT_SIGN_EN
        sign_d    = 1'b0;
`endif
        state_d   = S_TERM;
      end
      S_TERM: begin
        a_d = term_full[WIDTH-1:0];
        if (|term_full[2*WIDTH-1:WIDTH]) ovf_d = 1'b1;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (a_q > y_q) begin
          // Threshold hit: the term is dropped and the run ends.
          stopped_d = 1'b1;
          result_d  = r_q;
          state_d   = S_DONE;
        end else begin
          r_d     = acc_sum;
          terms_d = terms_q + TW'(1);
          if (acc_ovf) ovf_d = 1'b1;
          if (k_q == AW'(TERMS-1)) begin
            result_d = acc_sum;
            state_d  = S_DONE;
          end else begin
            // Power only advances when another term follows.
            p_d = pow_full[WIDTH-1:0];
            if (|pow_full[2*WIDTH-1:WIDTH]) ovf_d = 1'b1;
            k_d = k_q + AW'(1);
`ifdef SERIES_ALT_SIGN_EN
            if (alt_q) sign_d = ~sign_q;
`endif
            state_d = S_TERM;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      x2_q      <= '0;
      p_q       <= '0;
      r_q       <= '0;
      a_q       <= '0;
      k_q       <= '0;
      result_q  <= '0;
      terms_q   <= '0;
      stopped_q <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef SERIES_ALT_SIGN_EN
      alt_q     <= 1'b0;
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x2_q      <= x2_d;
      p_q       <= p_d;
      r_q       <= r_d;
      a_q       <= a_d;
      k_q       <= k_d;
      result_q  <= result_d;
      terms_q   <= terms_d;
      stopped_q <= stopped_d;
      ovf_q     <= ovf_d;
`ifdef SERIES_ALT_SIGN_EN
      alt_q     <= alt_d;
      sign_q    <= sign_d;
`endif
    end
  end

  // Coefficient file: writable only while idle, so a write paired with start
  // lands before the first TERM reads it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < TERMS; i++) coef_q[i] <= '0;
    end else if (state_q == S_IDLE && coef_we_i && (int'(coef_addr_i) < TERMS)) begin
      coef_q[coef_addr_i] <= coef_data_i;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign result_o     = result_q;
  assign terms_used_o = terms_q;
  assign stopped_o    = stopped_q;
  assign overflow_o   = ovf_q;

endmodule

// File: doc/series_engine.md
# series_engine

Self-sequencing power-series evaluator: computes R = Σ ±c[k]·(x²)^k for k = 0..TERMS-1, with early termination when a term exceeds a threshold. Successor to the fixed 16-bit, 8-term, externally-controlled series datapath. Width, term count and coefficient width are parametrised. The controller, start/done handshake, writable coefficient file and overflow detection are internal.

## Interface
- WIDTH, 16: datapath width of x, y, x², power, term and result
- TERMS, 8: maximum term count and coefficient-file depth (≥2)
- COEF_W, 8: coefficient width, unsigned, zero-extended to WIDTH
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- x  in  WIDTH  unsigned argument, captured on the start edge
- y  in  WIDTH  unsigned stop threshold, captured on the start edge
- alt  in  1  alternating-sign request, captured on the start edge
- coef_we  in  1  coefficient write strobe; honoured only in IDLE
- coef_addr  in  $clog2(TERMS)  coefficient index
- coef_data  in  COEF_W  coefficient value
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- result  out  WIDTH  two's-complement sum; held from DONE until the next start
- terms_used  out  $clog2(TERMS+1)  number of terms accumulated
- stopped  out  1  run ended by threshold, not by term count
- overflow  out  1  sticky per run; any truncation or signed-add overflow

## Operation
- States: IDLE → SQUARE → TERM ⇄ ACCUM → DONE → IDLE.
- IDLE: on start, capture x, y, alt and go to SQUARE. If coef_we is high, write coef_data to c[coef_addr].
- SQUARE: X2 = low WIDTH bits of x·x. Set P = 1, R = 0, k = 0, sign = +. Clear stopped and overflow, then set overflow if the high half of x·x is nonzero.
- TERM: A = low WIDTH bits of zext(c[k])·P. Set overflow if the high half is nonzero.
- ACCUM when A > y (unsigned):
  - A is discarded.
  - stopped = 1; go to DONE.
- ACCUM otherwise:
  - R = R ± A; set overflow on signed add overflow.
  - Increment terms_used.
  - If k = TERMS-1, go to DONE.
  - Else P = low WIDTH bits of P·X2 (overflow if high half nonzero), k++, toggle sign if alt is active, go to TERM.
- P is never updated after the final term, so no spurious overflow is flagged.
- DONE: done = 1, result = R; go to IDLE.
- start during busy: ignored. coef_we during busy: dropped.
- start and coef_we on the same IDLE edge: the write lands before the first TERM, so the run uses the new value.

## Timing
- Start sampled at edge e0.
- A run that evaluates N terms (including a discarded threshold term) has DONE during the cycle after edge e(2N+1).
- Full run with TERMS = 8: done 17 cycles after the start edge.
- busy rises the cycle after the start edge and falls the cycle after done.
- A new start is accepted in the cycle after DONE.
- Reset values: busy 0, done 0, result 0, terms_used 0, stopped 0, overflow 0, all coefficients 0, state IDLE.
- rst mid-run: return to IDLE on that edge with all reset values; the partial result is lost.

## Configuration
- SERIES_ALT_SIGN_EN defined: alt = 1 gives signs +, −, +, … per accumulated term.
- SERIES_ALT_SIGN_EN undefined: the alt port is ignored, all terms are added, and no sign flop is built.

## Test plan
- WIDTH=16, TERMS=8, all c=1, x=2, y=0xFFFF, alt=0 → result 0x5555 (21845), terms_used 8, stopped 0, overflow 0, done 17 cycles after start.
- Same with alt=1 and SERIES_ALT_SIGN_EN defined → result 0xCCCD (−13107). With the macro undefined → 0x5555.
- All c=1, x=2, y=100, alt=0 → result 85, terms_used 4, stopped 1, done 11 cycles after start.
- x=256 → X2 truncates to 0, overflow 1, result 1 (c[0]=1, P=1). Next start with x=2 clears overflow.
- Write c[3]=5 in IDLE → that coefficient is used. start pulsed and coef_we (c[0]=9) issued at cycle 4 of a run → both ignored; result unchanged versus the previous run.
- rst asserted 5 cycles into a run → next cycle busy 0, result 0, coefficients 0. Rewrite coefficients, start → correct fresh result.
